neopixel_strand_controller_param: RTL and testbench

Parametrised NeoPixel (WS2812-class) strand driver: stores a 24-bit GRB colour per pixel for `NUM_PIXELS` pixels, serialises the whole frame on a single-wire `neo_data` output with configurable bit timing, then holds the line low for a latch/reset interval. It generalises the fixed 5-pixel controller in four ways: arbitrary strand length, parametrised timing, MSB-first wire order and a registered output. An optional shadow frame buffer allows colour loads during transmission. It sits between the host register interface and the LED strand pin.

---
 rtl/neopixel_strand_controller_param.sv | 206 ++++++++++++++++++++
 tb/tb_neopixel_strand_controller_param.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_strand_controller_param.sv
// Purpose: WS2812-class strand driver; per-pixel GRB storage serialised MSB-first on a flopped neo_data pin.
// Latency: neo_data rises one cycle after send_it is accepted; frame ends with RESET_CYCLES of low latch time.
// Backpressure: ready_to_send only in IDLE (busy sends dropped); ready_to_load gated to IDLE/LATCH unless NEO_SHADOW_BUFFER_EN.
module neopixel_strand_controller_param #(
    parameter int NUM_PIXELS   = 8,
    parameter int T1H          = 35,
    parameter int T1L          = 30,
    parameter int T0H          = 18,
    parameter int T0L          = 40,
    parameter int RESET_CYCLES = 2500
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic [7:0]                                          color_level,
    input  logic [1:0]                                          color_index,
    input  logic [((NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1)-1:0] pixel_index,
    input  logic                                                load_color,
    input  logic                                                send_it,
    output logic                                                neo_data,
    output logic                                                ready_to_load,
    output logic                                                ready_to_send
);

    localparam int PIX_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int BW      = $clog2(24 * NUM_PIXELS);
    localparam int MAX_1   = T1H + T1L;
    localparam int MAX_0   = T0H + T0L;
    localparam int MAX_B   = (MAX_1 > MAX_0) ? MAX_1 : MAX_0;
    localparam int CYC_MAX = (MAX_B > RESET_CYCLES) ? MAX_B : RESET_CYCLES;
    localparam int CW      = $clog2(CYC_MAX + 1);

    localparam logic [CW-1:0] T1H_END  = CW'(T1H - 1);
    localparam logic [CW-1:0] T1L_END  = CW'(T1L - 1);
    localparam logic [CW-1:0] T0H_END  = CW'(T0H - 1);
    localparam logic [CW-1:0] T0L_END  = CW'(T0L - 1);
    localparam logic [CW-1:0] RST_END  = CW'(RESET_CYCLES - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(24 * NUM_PIXELS - 1);

`ifdef NEO_SHADOW_BUFFER_EN
    localparam logic LOAD_IN_FRAME = 1'b1;
`else
    localparam logic LOAD_IN_FRAME = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_LATCH} state_t;

    state_t          state;
    logic [CW-1:0]   cyc_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [4:0]      sub_cnt;

    // Transmitted frame buffer
    logic [7:0] red_q [NUM_PIXELS];
    logic [7:0] grn_q [NUM_PIXELS];
    logic [7:0] blu_q [NUM_PIXELS];

    logic        load_acc;
    logic        send_acc;
    logic [23:0] cur_word;
    logic        cur_bit;
    logic [CW-1:0] hi_end;
    logic [CW-1:0] lo_end;

    assign load_acc = load_color & ready_to_load;
`ifdef NEO_SHADOW_BUFFER_EN
    // Loads and sends coexist: the copy takes the pre-load shadow
    assign send_acc = send_it & ready_to_send;
`else
    // A simultaneous load wins and the send is dropped
    assign send_acc = send_it & ready_to_send & ~load_color;
`endif

    // Select the bit on the wire: GRB order, MSB first within the pixel
    always_comb begin
        cur_word = {grn_q[pix_cnt], red_q[pix_cnt], blu_q[pix_cnt]};
        cur_bit  = cur_word[5'd23 - sub_cnt];
        hi_end   = cur_bit ? T1H_END : T0H_END;
        lo_end   = cur_bit ? T1L_END : T0L_END;
    end

`ifdef NEO_SHADOW_BUFFER_EN
    logic [7:0] red_sh [NUM_PIXELS];
    logic [7:0] grn_sh [NUM_PIXELS];
    logic [7:0] blu_sh [NUM_PIXELS];

    // Loads land in the shadow; the active buffer is refreshed only when a frame starts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                red_sh[p] <= 8'h00;
                grn_sh[p] <= 8'h00;
                blu_sh[p] <= 8'h00;
                red_q[p]  <= 8'h00;
                grn_q[p]  <= 8'h00;
                blu_q[p]  <= 8'h00;
            end
        end else begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                if (send_acc) begin
                    red_q[p] <= red_sh[p];
                    grn_q[p] <= grn_sh[p];
                    blu_q[p] <= blu_sh[p];
                end
                if (load_acc && pixel_index == PIX_W'(p)) begin
                    case (color_index)
                        2'd0:    red_sh[p] <= color_level;
                        2'd1:    blu_sh[p] <= color_level;
                        2'd2:    grn_sh[p] <= color_level;
                        default: ;
                    endcase
                end
            end
        end
    end
`else
    // Single buffer written directly; out-of-range pixel indices match no entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                red_q[p] <= 8'h00;
                grn_q[p] <= 8'h00;
                blu_q[p] <= 8'h00;
            end
        end else begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                if (load_acc && pixel_index == PIX_W'(p)) begin
                    case (color_index)
                        2'd0:    red_q[p] <= color_level;
                        2'd1:    blu_q[p] <= color_level;
                        2'd2:    grn_q[p] <= color_level;
                        default: ;
                    endcase
                end
            end
        end
    end
`endif

    // Bit-timing FSM; neo_data follows the HIGH state one cycle later from a flop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            cyc_cnt       <= '0;
            bit_cnt       <= '0;
            pix_cnt       <= '0;
            sub_cnt       <= '0;
            neo_data      <= 1'b0;
            ready_to_send <= 1'b1;
            ready_to_load <= 1'b1;
        end else begin
            neo_data <= (state == ST_HIGH);
            case (state)
                ST_IDLE: begin
                    if (send_acc) begin
                        state         <= ST_HIGH;
                        cyc_cnt       <= '0;
                        bit_cnt       <= '0;
                        pix_cnt       <= '0;
                        sub_cnt       <= '0;
                        ready_to_send <= 1'b0;
                        ready_to_load <= LOAD_IN_FRAME;
                    end
                end
                ST_HIGH: begin
                    if (cyc_cnt == hi_end) begin
                        state   <= ST_LOW;
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cyc_cnt == lo_end) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state         <= ST_LATCH;
                            ready_to_load <= 1'b1;
                        end else begin
                            state   <= ST_HIGH;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (sub_cnt == 5'd23) begin
                                sub_cnt <= '0;
                                pix_cnt <= pix_cnt + 1'b1;
                            end else begin
                                sub_cnt <= sub_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    if (cyc_cnt == RST_END) begin
                        state         <= ST_IDLE;
                        cyc_cnt       <= '0;
                        ready_to_send <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_strand_controller_param.sv
// Purpose: randomized self-checking bench for the NeoPixel strand controller against a frame-level model.
// Latency: expects neo_data to rise one cycle after the accepting edge and readiness back after frame+latch.
// Backpressure: checks dropped sends/loads while busy and load/send collision behaviour for either build.
module tb_neopixel_strand_controller_param;

    localparam int N  = 5;
    localparam int T1H = 7;
    localparam int T1L = 5;
    localparam int T0H = 3;
    localparam int T0L = 8;
    localparam int R  = 40;

`ifdef NEO_SHADOW_BUFFER_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] color_level = '0;
    logic [1:0] color_index = '0;
    logic [2:0] pixel_index = '0;
    logic       load_color = 1'b0;
    logic       send_it = 1'b0;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;

    int checks = 0;
    int errors = 0;

    // Model: loads write sh_*, a started frame transmits act_*
    logic [7:0] sh_r [N];
    logic [7:0] sh_g [N];
    logic [7:0] sh_b [N];
    logic [7:0] act_r [N];
    logic [7:0] act_g [N];
    logic [7:0] act_b [N];
    bit wave[$];

    neopixel_strand_controller_param #(
        .NUM_PIXELS(N), .T1H(T1H), .T1L(T1L), .T0H(T0H), .T0L(T0L), .RESET_CYCLES(R)
    ) dut (
        .clock(clock), .reset(reset), .color_level(color_level), .color_index(color_index),
        .pixel_index(pixel_index), .load_color(load_color), .send_it(send_it),
        .neo_data(neo_data), .ready_to_load(ready_to_load), .ready_to_send(ready_to_send)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int p = 0; p < N; p++) begin
            sh_r[p] = 0; sh_g[p] = 0; sh_b[p] = 0;
            act_r[p] = 0; act_g[p] = 0; act_b[p] = 0;
        end
    endtask

    task automatic model_load(input int pix, input int col, input int lvl);
        if (pix < N) begin
            case (col)
                0: sh_r[pix] = lvl[7:0];
                1: sh_b[pix] = lvl[7:0];
                2: sh_g[pix] = lvl[7:0];
                default: ;
            endcase
        end
    endtask

    task automatic model_copy();
        for (int p = 0; p < N; p++) begin
            act_r[p] = sh_r[p]; act_g[p] = sh_g[p]; act_b[p] = sh_b[p];
        end
    endtask

    task automatic build_wave();
        logic [23:0] w;
        wave.delete();
        for (int p = 0; p < N; p++) begin
            w = {act_g[p], act_r[p], act_b[p]};
            for (int b = 23; b >= 0; b--) begin
                if (w[b]) begin
                    repeat (T1H) wave.push_back(1'b1);
                    repeat (T1L) wave.push_back(1'b0);
                end else begin
                    repeat (T0H) wave.push_back(1'b1);
                    repeat (T0L) wave.push_back(1'b0);
                end
            end
        end
    endtask

    task automatic do_load(input int pix, input int col, input int lvl);
        checks++;
        if (ready_to_load !== 1'b1) begin
            errors++;
            $display("FAIL load_ready: ready_to_load=%b required 1", ready_to_load);
        end
        pixel_index = pix[2:0];
        color_index = col[1:0];
        color_level = lvl[7:0];
        load_color  = 1'b1;
        tick();
        load_color  = 1'b0;
        model_load(pix, col, lvl);
    endtask

    // Called just after the accepting edge; load_at = -2 means two cycles into LATCH
    task automatic run_frame(input string name, input int load_at, input int send_at,
                             input int lpix, input int lcol, input int llvl);
        int p_len, la, bad_neo, bad_rs, bad_rl, first_j;
        bit exp_neo, exp_rs, exp_rl;
        build_wave();
        p_len = wave.size();
        la = (load_at == -2) ? p_len + 2 : load_at;
        bad_neo = 0; bad_rs = 0; bad_rl = 0; first_j = -1;
        checks++;
        if (neo_data !== 1'b0) begin
            errors++;
            $display("FAIL %s_first_edge: neo_data=%b required 0", name, neo_data);
        end
        for (int j = 1; j <= p_len + R; j++) begin
            tick();
            exp_neo = (j <= p_len) ? wave[j-1] : 1'b0;
            exp_rs  = (j == p_len + R);
            exp_rl  = SHADOW ? 1'b1 : (j >= p_len);
            if (neo_data !== exp_neo) begin
                if (bad_neo == 0) first_j = j;
                bad_neo++;
            end
            if (ready_to_send !== exp_rs) bad_rs++;
            if (ready_to_load !== exp_rl) bad_rl++;
            if (j == la + 1) load_color = 1'b0;
            if (j == send_at + 1) send_it = 1'b0;
            if (j == la) begin
                pixel_index = lpix[2:0];
                color_index = lcol[1:0];
                color_level = llvl[7:0];
                load_color  = 1'b1;
                if (SHADOW || j >= p_len) model_load(lpix, lcol, llvl);
            end
            if (j == send_at) send_it = 1'b1;
        end
        load_color = 1'b0;
        send_it = 1'b0;
        checks++;
        if (bad_neo != 0) begin
            errors++;
            $display("FAIL %s_wave: %0d wrong neo_data cycles, first at cycle %0d of %0d", name, bad_neo, first_j, p_len + R);
        end
        checks++;
        if (bad_rs != 0) begin
            errors++;
            $display("FAIL %s_ready_send: %0d cycles differ from required low-for-%0d", name, bad_rs, p_len + R - 1);
        end
        checks++;
        if (bad_rl != 0) begin
            errors++;
            $display("FAIL %s_ready_load: %0d cycles differ from required pattern", name, bad_rl);
        end
    endtask

    task automatic send_frame(input string name, input int load_at, input int send_at,
                              input int lpix, input int lcol, input int llvl);
        checks++;
        if (ready_to_send !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before: ready_to_send=%b required 1", name, ready_to_send);
        end
        send_it = 1'b1;
        tick();
        send_it = 1'b0;
        model_copy();
        run_frame(name, load_at, send_at, lpix, lcol, llvl);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        repeat (3) tick();
        checks++;
        if (neo_data !== 1'b0) begin errors++; $display("FAIL reset_neo: got %b required 0", neo_data); end
        checks++;
        if (ready_to_load !== 1'b1) begin errors++; $display("FAIL reset_rdy_load: got %b required 1", ready_to_load); end
        checks++;
        if (ready_to_send !== 1'b1) begin errors++; $display("FAIL reset_rdy_send: got %b required 1", ready_to_send); end
        reset = 1'b1;
        tick();
        checks++;
        if (ready_to_send !== 1'b1 || neo_data !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: rdy_send=%b neo=%b required 1/0", ready_to_send, neo_data);
        end
    endtask

    task automatic test_all_zero();
        send_frame("all_zero", -1, -1, 0, 0, 0);
    endtask

    task automatic test_single_pattern();
        do_load(0, 2, 8'h80);
        do_load(0, 0, 8'h01);
        do_load(0, 1, 8'h00);
        send_frame("pattern", -1, -1, 0, 0, 0);
    endtask

    task automatic test_invalid_loads();
        do_load(5, 0, 8'hFF);
        do_load(7, 2, 8'hAA);
        do_load(1, 3, 8'h55);
        send_frame("invalid", -1, -1, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        int bad;
        pixel_index = 3'd2;
        color_index = 2'd2;
        color_level = 8'hC3;
        load_color  = 1'b1;
        send_it     = 1'b1;
        tick();
        load_color = 1'b0;
        send_it    = 1'b0;
        if (SHADOW) begin
            model_copy();
            model_load(2, 2, 8'hC3);
            run_frame("simul_old", -1, -1, 0, 0, 0);
        end else begin
            model_load(2, 2, 8'hC3);
            bad = 0;
            for (int j = 0; j < 10; j++) begin
                if (neo_data !== 1'b0 || ready_to_send !== 1'b1) bad++;
                tick();
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL simul_no_frame: %0d cycles with neo/ready not 0/1", bad);
            end
        end
        send_frame("simul_new", -1, -1, 0, 0, 0);
    endtask

    task automatic test_load_during_frame();
        send_frame("load_high", 1, -1, 3, 0, 8'h5A);
        send_frame("load_high_next", -1, -1, 0, 0, 0);
    endtask

    task automatic test_load_during_latch();
        send_frame("load_latch", -2, -1, 4, 1, 8'hE7);
        send_frame("load_latch_next", -1, -1, 0, 0, 0);
    endtask

    task automatic test_send_while_busy();
        send_frame("busy_send", -1, 20, 0, 0, 0);
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(10, 3);
            for (int i = 0; i < n; i++)
                do_load($urandom_range(7, 0), $urandom_range(3, 0), $urandom_range(255, 0));
            send_frame("random", $urandom_range(80, 1), -1,
                       $urandom_range(7, 0), $urandom_range(3, 0), $urandom_range(255, 0));
        end
    endtask

    task automatic test_back_to_back();
        send_frame("b2b_first", -1, -1, 0, 0, 0);
        send_frame("b2b_second", -1, -1, 0, 0, 0);
    endtask

    task automatic test_reset_mid_frame();
        do_load(0, 2, 8'hFF);
        send_it = 1'b1;
        tick();
        send_it = 1'b0;
        tick();
        tick();
        checks++;
        if (neo_data !== 1'b1) begin errors++; $display("FAIL midrst_high: neo_data=%b required 1", neo_data); end
        #1;
        reset = 1'b0;
        #1;
        model_clear();
        checks++;
        if (neo_data !== 1'b0) begin errors++; $display("FAIL midrst_neo: neo_data=%b required 0", neo_data); end
        checks++;
        if (ready_to_load !== 1'b1 || ready_to_send !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: load=%b send=%b required 1/1", ready_to_load, ready_to_send);
        end
        tick();
        reset = 1'b1;
        tick();
        send_frame("midrst_zero", -1, -1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_pattern();
        test_invalid_loads();
        test_simultaneous();
        test_load_during_frame();
        test_load_during_latch();
        test_send_while_busy();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
